// File: rtl/vcm_i2c_slave_if.sv
// Focus-path side of the VCM I2C responder: committed code, strobes, busy and FSM state.
// The responder drives through "slave"; anything observing the focus path uses "master".
interface vcm_i2c_slave_if;
    logic [15:0] VCM_DATA;
    logic        WR_STB;
    logic        BUSY;
    logic        ADDR_HIT;
    logic [3:0]  ST;

    modport slave  (output VCM_DATA, WR_STB, BUSY, ADDR_HIT, ST);
    modport master (input  VCM_DATA, WR_STB, BUSY, ADDR_HIT, ST);
endinterface

// File: rtl/vcm_i2c_slave.sv
// VCM focus-driver I2C responder: 16-bit code write, 16-bit status read (bit 15 busy); 3-cycle pin-to-detect,
// SDA updated 4 cycles after detected SCL fall; no clock stretching. Busy counter only with VCM_SLAVE_BUSY_MODEL_EN.
module vcm_i2c_slave #(
    parameter logic [6:0]  SLAVE_ADDR  = 7'h0C,
    parameter int unsigned BUSY_CYCLES = 50000
) (
    input  logic           CLK_50,
    input  logic           RESET_N,
    input  logic           I2C_SCL,
    inout  wire            I2C_SDA,
    vcm_i2c_slave_if.slave vcm
);
    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_ADDR     = 4'd1,
        S_ADDR_ACK = 4'd2,
        S_WR_BYTE  = 4'd3,
        S_WR_ACK   = 4'd4,
        S_RD_BYTE  = 4'd5,
        S_RD_ACK   = 4'd6,
        S_IGNORE   = 4'd7
    } state_t;

    logic scl_s1_q, scl_s2_q, scl_h_q, sda_s1_q, sda_s2_q, sda_h_q;
    state_t      state_q, state_d;
    logic [3:0]  bit_cnt_q, bit_cnt_d;
    logic [1:0]  byte_idx_q, byte_idx_d;
    logic [7:0]  shift_q, shift_d, hi_q, hi_d;
    logic [15:0] status_q, status_d, vcm_q, vcm_d;
    logic        rd_lo_q, rd_lo_d, rw_q, rw_d, nack_q, nack_d;
    logic        wr_stb_q, wr_stb_d, addr_hit_q, addr_hit_d;
    logic        sda_oe_q, sda_oe_d, sda_pend_q, sda_pend_d;
    logic [2:0]  dly_q, dly_d;
    logic        busy, drv_set, drv_val;
    logic [7:0]  shift_in, rd_byte;

    wire scl_rise  =  scl_s2_q & ~scl_h_q;
    wire scl_fall  = ~scl_s2_q &  scl_h_q;
    wire start_det =  scl_s2_q &  scl_h_q &  sda_h_q & ~sda_s2_q;
    wire stop_det  =  scl_s2_q &  scl_h_q & ~sda_h_q &  sda_s2_q;

    // Released combinationally in reset so a held-low bit cannot outlive RESET_N.
    assign I2C_SDA = (sda_oe_q & RESET_N) ? 1'b0 : 1'bz;

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        byte_idx_d = byte_idx_q;
        shift_d    = shift_q;
        hi_d       = hi_q;
        status_d   = status_q;
        vcm_d      = vcm_q;
        rd_lo_d    = rd_lo_q;
        rw_d       = rw_q;
        nack_d     = nack_q;
        wr_stb_d   = 1'b0;
        addr_hit_d = 1'b0;
        sda_oe_d   = sda_oe_q;
        sda_pend_d = sda_pend_q;
        dly_d      = dly_q;
        drv_set    = 1'b0;
        drv_val    = 1'b0;
        shift_in   = {shift_q[6:0], sda_s2_q};
        rd_byte    = rd_lo_q ? status_q[7:0] : status_q[15:8];

        if (dly_q != 3'd0) begin
            dly_d = dly_q - 3'd1;
            if (dly_q == 3'd1) sda_oe_d = sda_pend_q;
        end

        if (start_det) begin
            state_d    = S_ADDR;
            bit_cnt_d  = 4'd0;
            byte_idx_d = 2'd0;
            sda_oe_d   = 1'b0;
            dly_d      = 3'd0;
        end else if (stop_det) begin
            state_d  = S_IDLE;
            sda_oe_d = 1'b0;
            dly_d    = 3'd0;
        end else begin
            case (state_q)
                S_ADDR: begin
                    if (scl_rise && bit_cnt_q < 4'd8) begin
                        shift_d   = shift_in;
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        if (bit_cnt_q == 4'd7) begin
                            if (shift_in[7:1] == SLAVE_ADDR) begin
                                addr_hit_d = 1'b1;
                                rw_d       = shift_in[0];
                                status_d   = {busy, vcm_q[14:0]};
                            end else begin
                                state_d = S_IGNORE;
                            end
                        end
                    end else if (scl_fall && bit_cnt_q == 4'd8) begin
                        state_d = S_ADDR_ACK;
                        drv_set = 1'b1;
                        drv_val = 1'b1;
                    end
                end
                S_ADDR_ACK: begin
                    if (scl_fall) begin
                        drv_set = 1'b1;
                        if (rw_q) begin
                            state_d   = S_RD_BYTE;
                            rd_lo_d   = 1'b1;
                            shift_d   = {status_q[14:8], 1'b0};
                            drv_val   = ~status_q[15];
                            bit_cnt_d = 4'd1;
                        end else begin
                            state_d   = S_WR_BYTE;
                            bit_cnt_d = 4'd0;
                        end
                    end
                end
                S_WR_BYTE: begin
                    if (scl_rise && bit_cnt_q < 4'd8) begin
                        shift_d   = shift_in;
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        if (bit_cnt_q == 4'd7) begin
                            nack_d = (byte_idx_q == 2'd2);
                            if (byte_idx_q == 2'd0) hi_d = shift_in;
                            if (byte_idx_q == 2'd1) begin
                                vcm_d    = {hi_q, shift_in};
                                wr_stb_d = 1'b1;
                            end
                            if (byte_idx_q != 2'd2) byte_idx_d = byte_idx_q + 2'd1;
                        end
                    end else if (scl_fall && bit_cnt_q == 4'd8) begin
                        state_d = S_WR_ACK;
                        drv_set = 1'b1;
                        drv_val = ~nack_q;
                    end
                end
                S_WR_ACK: begin
                    if (scl_fall) begin
                        drv_set   = 1'b1;
                        bit_cnt_d = 4'd0;
                        state_d   = nack_q ? S_IGNORE : S_WR_BYTE;
                    end
                end
                S_RD_BYTE: begin
                    if (scl_fall) begin
                        drv_set = 1'b1;
                        if (bit_cnt_q == 4'd8) begin
                            state_d = S_RD_ACK;
                        end else begin
                            drv_val   = ~shift_q[7];
                            shift_d   = {shift_q[6:0], 1'b0};
                            bit_cnt_d = bit_cnt_q + 4'd1;
                        end
                    end
                end
                S_RD_ACK: begin
                    // A released SDA at the ACK sample is the master's NACK.
                    if (scl_rise && sda_s2_q) begin
                        state_d = S_IGNORE;
                    end else if (scl_fall) begin
                        state_d   = S_RD_BYTE;
                        drv_set   = 1'b1;
                        drv_val   = ~rd_byte[7];
                        shift_d   = {rd_byte[6:0], 1'b0};
                        bit_cnt_d = 4'd1;
                        rd_lo_d   = ~rd_lo_q;
                    end
                end
                default: ;
            endcase
        end

        if (drv_set) begin
            sda_pend_d = drv_val;
            dly_d      = 3'd3;
        end
    end

    always_ff @(posedge CLK_50) begin
        if (!RESET_N) begin
            scl_s1_q   <= 1'b1;
            scl_s2_q   <= 1'b1;
            scl_h_q    <= 1'b1;
            sda_s1_q   <= 1'b1;
            sda_s2_q   <= 1'b1;
            sda_h_q    <= 1'b1;
            state_q    <= S_IDLE;
            bit_cnt_q  <= 4'd0;
            byte_idx_q <= 2'd0;
            shift_q    <= 8'd0;
            hi_q       <= 8'd0;
            status_q   <= 16'd0;
            vcm_q      <= 16'd0;
            rd_lo_q    <= 1'b0;
            rw_q       <= 1'b0;
            nack_q     <= 1'b0;
            wr_stb_q   <= 1'b0;
            addr_hit_q <= 1'b0;
            sda_oe_q   <= 1'b0;
            sda_pend_q <= 1'b0;
            dly_q      <= 3'd0;
        end else begin
            scl_s1_q   <= I2C_SCL;
            scl_s2_q   <= scl_s1_q;
            scl_h_q    <= scl_s2_q;
            sda_s1_q   <= I2C_SDA;
            sda_s2_q   <= sda_s1_q;
            sda_h_q    <= sda_s2_q;
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            byte_idx_q <= byte_idx_d;
            shift_q    <= shift_d;
            hi_q       <= hi_d;
            status_q   <= status_d;
            vcm_q      <= vcm_d;
            rd_lo_q    <= rd_lo_d;
            rw_q       <= rw_d;
            nack_q     <= nack_d;
            wr_stb_q   <= wr_stb_d;
            addr_hit_q <= addr_hit_d;
            sda_oe_q   <= sda_oe_d;
            sda_pend_q <= sda_pend_d;
            dly_q      <= dly_d;
        end
    end

`ifdef VCM_SLAVE_BUSY_MODEL_EN
    logic [31:0] busy_cnt_q;

    always_ff @(posedge CLK_50) begin
        if (!RESET_N)                busy_cnt_q <= 32'd0;
        else if (wr_stb_d)           busy_cnt_q <= BUSY_CYCLES;
        else if (busy_cnt_q != 32'd0) busy_cnt_q <= busy_cnt_q - 32'd1;
    end

    assign busy = (busy_cnt_q != 32'd0);
`else
    logic unused_busy_cfg;
    assign unused_busy_cfg = ^BUSY_CYCLES;
    assign busy = 1'b0;
`endif

    assign vcm.VCM_DATA = vcm_q;
    assign vcm.WR_STB   = wr_stb_q;
    assign vcm.BUSY     = busy;
    assign vcm.ADDR_HIT = addr_hit_q;
    assign vcm.ST       = state_q;
endmodule

// File: tb/tb_vcm_i2c_slave.sv
// Directed bit-banged I2C master against vcm_i2c_slave; expectations follow the busy-model build macro.
module tb_vcm_i2c_slave;
    localparam int          HP = 12;
    localparam int unsigned BC = 6000;
`ifdef VCM_SLAVE_BUSY_MODEL_EN
    localparam logic BUSY_ON = 1'b1;
`else
    localparam logic BUSY_ON = 1'b0;
`endif
    localparam logic [3:0] ST_IDLE = 4'd0, ST_RD_BYTE = 4'd5, ST_IGNORE = 4'd7;

    logic clk = 1'b0;
    logic rst_n, scl, m_sda_low;
    wire  sda_w;
    int   checks = 0, failures = 0;
    int   stb_cnt = 0, hit_cnt = 0, drv_cnt = 0;
    logic [15:0] stb_data = 16'h0;

    always #10 clk = ~clk;

    pullup (sda_w);
    assign sda_w = m_sda_low ? 1'b0 : 1'bz;

    vcm_i2c_slave_if ifc ();

    vcm_i2c_slave #(.SLAVE_ADDR(7'h0C), .BUSY_CYCLES(BC)) dut (
        .CLK_50 (clk),
        .RESET_N(rst_n),
        .I2C_SCL(scl),
        .I2C_SDA(sda_w),
        .vcm    (ifc)
    );

    always @(posedge clk) begin
        if (ifc.WR_STB === 1'b1) begin
            stb_cnt  <= stb_cnt + 1;
            stb_data <= ifc.VCM_DATA;
        end
        if (ifc.ADDR_HIT === 1'b1) hit_cnt <= hit_cnt + 1;
        if (!m_sda_low && sda_w === 1'b0) drv_cnt <= drv_cnt + 1;
    end

    task automatic hp();
        repeat (HP) @(negedge clk);
    endtask

    task automatic i2c_start();
        m_sda_low = 1'b0; hp(); scl = 1'b1; hp(); m_sda_low = 1'b1; hp(); scl = 1'b0; hp();
    endtask

    task automatic i2c_stop();
        repeat (3) @(negedge clk);
        m_sda_low = 1'b1; hp(); scl = 1'b1; hp(); m_sda_low = 1'b0; hp();
    endtask

    task automatic put_bit(input logic b);
        repeat (3) @(negedge clk);
        m_sda_low = ~b; hp(); scl = 1'b1; hp(); scl = 1'b0;
    endtask

    task automatic get_bit(output logic b);
        repeat (3) @(negedge clk);
        m_sda_low = 1'b0; hp(); scl = 1'b1;
        repeat (HP / 2) @(negedge clk);
        b = sda_w;
        repeat (HP / 2) @(negedge clk);
        scl = 1'b0;
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack);
        logic b;
        for (int i = 7; i >= 0; i--) put_bit(d[i]);
        get_bit(b);
        ack = ~b;
    endtask

    task automatic read_byte(output logic [7:0] d, input logic ack);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            get_bit(b);
            d[i] = b;
        end
        put_bit(~ack);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; scl = 1'b1; m_sda_low = 1'b0;
        repeat (4) @(negedge clk);
        checks++; if (ifc.VCM_DATA !== 16'h0) begin failures++; $display("FAIL reset_vcm_data: got %h want 0000", ifc.VCM_DATA); end
        checks++; if (ifc.WR_STB !== 1'b0) begin failures++; $display("FAIL reset_wr_stb: got %b want 0", ifc.WR_STB); end
        checks++; if (ifc.BUSY !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", ifc.BUSY); end
        checks++; if (ifc.ADDR_HIT !== 1'b0) begin failures++; $display("FAIL reset_addr_hit: got %b want 0", ifc.ADDR_HIT); end
        checks++; if (ifc.ST !== ST_IDLE) begin failures++; $display("FAIL reset_st: got %0d want %0d", ifc.ST, ST_IDLE); end
        checks++; if (sda_w !== 1'b1) begin failures++; $display("FAIL reset_sda: got %b want 1 (released)", sda_w); end
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_write_read();
        logic a0, a1, a2;
        logic [7:0] d0, d1;
        int s0, h0;
        s0 = stb_cnt; h0 = hit_cnt;
        i2c_start(); write_byte(8'h18, a0); write_byte(8'h03, a1); write_byte(8'hA5, a2); i2c_stop();
        checks++; if ({a0, a1, a2} !== 3'b111) begin failures++; $display("FAIL wr_acks: got %b want 111", {a0, a1, a2}); end
        checks++; if (stb_cnt - s0 !== 1) begin failures++; $display("FAIL wr_stb_count: got %0d want 1", stb_cnt - s0); end
        checks++; if (ifc.VCM_DATA !== 16'h03A5) begin failures++; $display("FAIL wr_vcm_data: got %h want 03a5", ifc.VCM_DATA); end
        checks++; if (stb_data !== 16'h03A5) begin failures++; $display("FAIL wr_data_at_stb: got %h want 03a5", stb_data); end
        checks++; if (ifc.BUSY !== BUSY_ON) begin failures++; $display("FAIL wr_busy: got %b want %b", ifc.BUSY, BUSY_ON); end
        i2c_start(); write_byte(8'h19, a0); read_byte(d0, 1'b1); read_byte(d1, 1'b0); i2c_stop();
        checks++; if (a0 !== 1'b1) begin failures++; $display("FAIL rd_addr_ack: got %b want 1", a0); end
        checks++; if (d0 !== {BUSY_ON, 7'h03}) begin failures++; $display("FAIL rd_busy_hi: got %h want %h", d0, {BUSY_ON, 7'h03}); end
        checks++; if (d1 !== 8'hA5) begin failures++; $display("FAIL rd_busy_lo: got %h want a5", d1); end
        checks++; if (hit_cnt - h0 !== 2) begin failures++; $display("FAIL addr_hit_count: got %0d want 2", hit_cnt - h0); end
        repeat (BC) @(negedge clk);
        checks++; if (ifc.BUSY !== 1'b0) begin failures++; $display("FAIL busy_expired: got %b want 0", ifc.BUSY); end
        i2c_start(); write_byte(8'h19, a0); read_byte(d0, 1'b1); read_byte(d1, 1'b0); i2c_stop();
        checks++; if ({a0, d0, d1} !== {1'b1, 16'h03A5}) begin failures++; $display("FAIL rd_idle_status: got %b %h%h want 1 03a5", a0, d0, d1); end
    endtask

    task automatic test_wrong_address();
        logic a0, a1;
        int dr0, h0;
        dr0 = drv_cnt; h0 = hit_cnt;
        i2c_start(); write_byte(8'h20, a0); write_byte(8'h5A, a1); i2c_stop();
        checks++; if ({a0, a1} !== 2'b00) begin failures++; $display("FAIL wa_acks: got %b want 00", {a0, a1}); end
        checks++; if (drv_cnt - dr0 !== 0) begin failures++; $display("FAIL wa_sda_driven: got %0d cycles want 0", drv_cnt - dr0); end
        checks++; if (hit_cnt - h0 !== 0) begin failures++; $display("FAIL wa_addr_hit: got %0d want 0", hit_cnt - h0); end
        checks++; if (ifc.VCM_DATA !== 16'h03A5) begin failures++; $display("FAIL wa_vcm_data: got %h want 03a5", ifc.VCM_DATA); end
        checks++; if (ifc.ST !== ST_IDLE) begin failures++; $display("FAIL wa_st_after_stop: got %0d want %0d", ifc.ST, ST_IDLE); end
    endtask

    task automatic test_short_write();
        logic a0, a1, a2, a3;
        int s0;
        s0 = stb_cnt;
        i2c_start(); write_byte(8'h18, a0); write_byte(8'h12, a1); i2c_stop();
        checks++; if ({a0, a1} !== 2'b11) begin failures++; $display("FAIL sw_acks: got %b want 11", {a0, a1}); end
        checks++; if (stb_cnt - s0 !== 0) begin failures++; $display("FAIL sw_no_stb: got %0d want 0", stb_cnt - s0); end
        checks++; if (ifc.VCM_DATA !== 16'h03A5) begin failures++; $display("FAIL sw_vcm_kept: got %h want 03a5", ifc.VCM_DATA); end
        s0 = stb_cnt;
        i2c_start(); write_byte(8'h18, a0); write_byte(8'h01, a1); write_byte(8'h02, a2); write_byte(8'h03, a3); i2c_stop();
        checks++; if ({a0, a1, a2, a3} !== 4'b1110) begin failures++; $display("FAIL lw_acks: got %b want 1110", {a0, a1, a2, a3}); end
        checks++; if (ifc.VCM_DATA !== 16'h0102) begin failures++; $display("FAIL lw_vcm_data: got %h want 0102", ifc.VCM_DATA); end
        checks++; if (stb_cnt - s0 !== 1) begin failures++; $display("FAIL lw_stb_count: got %0d want 1", stb_cnt - s0); end
    endtask

    task automatic test_read_continuation();
        logic a0;
        logic [7:0] d0, d1, d2;
        i2c_start(); write_byte(8'h19, a0); read_byte(d0, 1'b1); read_byte(d1, 1'b1); read_byte(d2, 1'b0);
        repeat (8) @(negedge clk);
        checks++; if ({a0, d0, d1, d2} !== {1'b1, BUSY_ON, 7'h01, 8'h02, BUSY_ON, 7'h01}) begin
            failures++; $display("FAIL rc_bytes: got %b %h %h %h want 1 %h 02 %h", a0, d0, d1, d2, {BUSY_ON, 7'h01}, {BUSY_ON, 7'h01}); end
        checks++; if (ifc.ST !== ST_IGNORE) begin failures++; $display("FAIL rc_st_after_nack: got %0d want %0d", ifc.ST, ST_IGNORE); end
        checks++; if (sda_w !== 1'b1) begin failures++; $display("FAIL rc_sda_released: got %b want 1", sda_w); end
        i2c_stop();
        i2c_start(); write_byte(8'h19, a0); read_byte(d0, 1'b0); i2c_stop();
        checks++; if (a0 !== 1'b1) begin failures++; $display("FAIL rc_next_start: got %b want 1", a0); end
    endtask

    task automatic test_repeated_start();
        logic a0, a1, a2;
        logic [7:0] d0, d1;
        int s0;
        s0 = stb_cnt;
        i2c_start(); write_byte(8'h18, a0); write_byte(8'h55, a1);
        i2c_start(); write_byte(8'h19, a2); read_byte(d0, 1'b1); read_byte(d1, 1'b0); i2c_stop();
        checks++; if ({a0, a1, a2} !== 3'b111) begin failures++; $display("FAIL rs_acks: got %b want 111", {a0, a1, a2}); end
        checks++; if ({d0, d1} !== {BUSY_ON, 15'h0102}) begin failures++; $display("FAIL rs_status: got %h%h want %h", d0, d1, {BUSY_ON, 15'h0102}); end
        checks++; if (ifc.VCM_DATA !== 16'h0102) begin failures++; $display("FAIL rs_vcm_kept: got %h want 0102", ifc.VCM_DATA); end
        checks++; if (stb_cnt - s0 !== 0) begin failures++; $display("FAIL rs_no_stb: got %0d want 0", stb_cnt - s0); end
    endtask

    task automatic test_reset_mid_read();
        logic a0, a1, a2;
        repeat (BC) @(negedge clk);
        i2c_start(); write_byte(8'h19, a0);
        repeat (10) @(negedge clk);
        checks++; if ({a0, sda_w, ifc.ST} !== {1'b1, 1'b0, ST_RD_BYTE}) begin
            failures++; $display("FAIL mr_driving_zero: got ack=%b sda=%b st=%0d want 1 0 %0d", a0, sda_w, ifc.ST, ST_RD_BYTE); end
        rst_n = 1'b0;
        #1;
        checks++; if (sda_w !== 1'b1) begin failures++; $display("FAIL mr_sda_release: got %b want 1", sda_w); end
        @(negedge clk);
        checks++; if (ifc.VCM_DATA !== 16'h0) begin failures++; $display("FAIL mr_vcm_reset: got %h want 0000", ifc.VCM_DATA); end
        checks++; if ({ifc.ST, ifc.BUSY, ifc.WR_STB, ifc.ADDR_HIT} !== {ST_IDLE, 3'b000}) begin
            failures++; $display("FAIL mr_outputs_reset: got st=%0d busy=%b stb=%b hit=%b want 0 0 0 0", ifc.ST, ifc.BUSY, ifc.WR_STB, ifc.ADDR_HIT); end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        i2c_start(); write_byte(8'h18, a0); write_byte(8'hBE, a1); write_byte(8'hEF, a2); i2c_stop();
        checks++; if ({a0, a1, a2} !== 3'b111) begin failures++; $display("FAIL mr_recover_acks: got %b want 111", {a0, a1, a2}); end
        checks++; if (ifc.VCM_DATA !== 16'hBEEF) begin failures++; $display("FAIL mr_recover_data: got %h want beef", ifc.VCM_DATA); end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_wrong_address();
        test_short_write();
        test_read_continuation();
        test_repeated_start();
        test_reset_mid_read();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached before completion");
        $fatal(1);
    end
endmodule

// File: doc/vcm_i2c_slave.md
# vcm_i2c_slave

I2C responder that models the VCM focus-driver: acknowledges slave address 0x18/0x19 (7-bit 0x0C), accepts a 16-bit code write and returns a 16-bit status on a 2-byte read, with bit 15 the busy flag. Sits on the camera I2C bus opposite the VCM I2C master. Used for self-test builds and closed-loop simulation of the focus path.

## Interface
- `SLAVE_ADDR`, 7'h0C: 7-bit device address (0x18 write, 0x19 read on the wire).
- `BUSY_CYCLES`, 50000: `CLK_50` cycles that busy stays set after a committed write.
- `CLK_50` input 1: system clock, 50 MHz. All logic is on the rising edge.
- `RESET_N` input 1: synchronous, active-low reset.
- `I2C_SCL` input 1: bus clock. Asynchronous to `CLK_50`.
- `I2C_SDA` inout 1: open-drain data. The block drives only 0 or `z`.
- `VCM_DATA` output 16: last committed code, `{first byte, second byte}`.
- `WR_STB` output 1: one-cycle pulse when `VCM_DATA` updates.
- `BUSY` output 1: busy flag, the same value as status bit 15.
- `ADDR_HIT` output 1: one-cycle pulse when the address matches and is ACKed.
- `ST` output 4: FSM state, for test.

## Operation
- **Synchronisers and edge detection:** SCL and SDA each pass through a 2-flop synchroniser plus a history flop. Edge detection runs on the synchronised values.
- **Bus conditions:** START is SDA falling while SCL is high. STOP is SDA rising while SCL is high.
- **States:** IDLE, ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK, IGNORE.
- **START:** from any state, clear the bit counter, set the byte index to 0, go to ADDR. A repeated START behaves the same.
- **STOP:** from any state, release SDA and go to IDLE.
- **ADDR:** shift 8 bits, MSB first, sampled on SCL rising.
  - Address match: go to ADDR_ACK.
  - Mismatch: go to IGNORE with SDA released (NACK).
- **ADDR_ACK:** drive SDA low for one SCL period and pulse `ADDR_HIT`. Then:
  - R/W=0: go to WR_BYTE.
  - R/W=1: load the shift register with `{BUSY, VCM_DATA[14:0]}`, go to RD_BYTE.
- **WR_BYTE:** shift 8 bits, go to WR_ACK.
  - Byte index 0: ACK, store the byte as the high byte.
  - Byte index 1: ACK, update `VCM_DATA`, pulse `WR_STB`, start busy.
  - Byte index 2 or higher: NACK, go to IGNORE after the ACK slot.
- **Short write:** if STOP arrives with only one data byte received, `VCM_DATA` is unchanged.
- **RD_BYTE:** drive the status MSB first. Order is high byte, then low byte, then wrap to the high byte. The status word is latched once per address phase.
- **RD_ACK:** sample the master's ACK.
  - ACK: continue with the next byte.
  - NACK: go to IGNORE.
- **Busy counter:** 32-bit. Loads `BUSY_CYCLES` on commit and counts down to 0. `BUSY` = counter != 0. A commit during busy reloads the counter.

## Timing
- **Reset values:** `VCM_DATA`=0, `WR_STB`=0, `BUSY`=0, `ADDR_HIT`=0, `ST`=IDLE, SDA=`z`.
- **Detection latency:** 3 `CLK_50` cycles from a pin edge to internal detection.
- **SDA output:** changes only 4 `CLK_50` cycles after SCL falling is detected, giving hold of at least 80 ns. SDA is never changed while synchronised SCL is high, except on release for STOP/START.
- **ACK slot:** driven from the SCL falling edge after bit 8 to the next SCL falling edge.
- **Write commit:** `WR_STB` fires 1 cycle after the SCL rising edge that samples bit 8 of the second data byte. `VCM_DATA` is valid in the same cycle as `WR_STB`.
- **`ADDR_HIT`:** fires in the same relative cycle, for the address byte.
- **Reset during a transfer:** SDA is released immediately and the FSM returns to IDLE. The bus recovers on the next START.
- **Supported SCL:** up to 400 kHz at `CLK_50` = 50 MHz. SCL high and low must each be at least 8 `CLK_50` cycles.

## Configuration
- **`VCM_SLAVE_BUSY_MODEL_EN` defined:** busy counter present, behaving as above.
- **`VCM_SLAVE_BUSY_MODEL_EN` undefined:** counter removed, `BUSY` tied to 0, status bit 15 always reads 0, `BUSY_CYCLES` ignored.

## Test plan
- **Write then read:** START, 0x18, 0x03, 0xA5, STOP.
  - 3 ACKs, `WR_STB` one pulse, `VCM_DATA`=0x03A5, `BUSY`=1.
  - Immediate read 0x19 returns 0x83, 0xA5.
  - After `BUSY_CYCLES` cycles the read returns 0x03, 0xA5.
- **Wrong address:** START, 0x20, byte, STOP. SDA never driven, no `ADDR_HIT`, `VCM_DATA` unchanged.
- **Short write:** START, 0x18, 0x12, STOP. Both ACKed, no `WR_STB`, `VCM_DATA` keeps its old value. A 3-byte write 0x18, 0x01, 0x02, 0x03 NACKs the third byte and `VCM_DATA`=0x0102.
- **Read continuation:** 3-byte read with master ACK, ACK, NACK returns high, low, high. SDA is released after the NACK. Next START is accepted.
- **Repeated START:** START, 0x18, 0x55, rSTART, 0x19, read 2 bytes. Returns the prior status, `VCM_DATA` unchanged.
- **Reset mid-read:** `RESET_N`=0 while a 0 bit is being driven. SDA is `z` the next cycle and all outputs return to their reset values.
